// File: rtl/image_feeder.sv
// Streaming pixel source for the line-buffer window generator: preloads four lines,
// then releases one line per downstream line-consumed interrupt until the frame is done.
module image_feeder #(
  parameter int INTEGER_BITS     = 9,
  parameter int FIXED_POINT_BITS = 4,
  parameter int IMG_WIDTH        = 512,
  parameter int IMG_HEIGHT       = 512,
  parameter int ADDR_WIDTH       = 18
) (
  input  logic                                     i_clk,
  input  logic                                     i_rst_n,
  input  logic                                     i_start,
  output logic [ADDR_WIDTH-1:0]                    o_mem_addr,
  output logic                                     o_mem_rd_en,
  input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] i_mem_data,
  output logic [INTEGER_BITS+FIXED_POINT_BITS-1:0] o_pixel_data,
  output logic                                     o_pixel_data_valid,
  input  logic                                     i_intr,
  output logic                                     o_busy,
  output logic                                     o_done
);

  localparam int DW = INTEGER_BITS + FIXED_POINT_BITS;
  localparam int CW = (IMG_WIDTH > 1) ? $clog2(IMG_WIDTH) : 1;
  localparam int LW = $clog2(IMG_HEIGHT + 1);

  typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_DRAIN, S_DONE} state_t;

  state_t                r_state, w_state_nxt;
  logic [2:0]            r_credit, w_credit_nxt;
  logic [LW-1:0]         r_lines_sent, w_lines_nxt;
  logic [LW-1:0]         r_intr_cnt, w_intr_nxt;
  logic [CW-1:0]         r_col, w_col_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic                  r_rd_d1, r_valid;
  logic [DW-1:0]         r_pix;

  logic w_intr_act, w_line_start, w_line_end;

  assign w_intr_act   = i_intr && (r_state != S_IDLE);
  assign w_line_start = (r_state == S_SEND) && (r_col == '0);
  assign w_line_end   = (r_state == S_SEND) && (r_col == CW'(IMG_WIDTH - 1));

  always_comb begin
    w_state_nxt  = r_state;
    w_credit_nxt = r_credit;
    w_lines_nxt  = r_lines_sent;
    w_intr_nxt   = r_intr_cnt;
    w_col_nxt    = r_col;
    w_addr_nxt   = r_addr;

    // A line start and an interrupt in the same cycle cancel out.
    if (w_line_start && !w_intr_act)
      w_credit_nxt = r_credit - 3'd1;
    else if (!w_line_start && w_intr_act && (r_credit < 3'd4))
      w_credit_nxt = r_credit + 3'd1;

    if (w_intr_act && (r_intr_cnt < LW'(IMG_HEIGHT - 2)))
      w_intr_nxt = r_intr_cnt + 1'b1;

    unique case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_credit_nxt = 3'd4;
          w_lines_nxt  = '0;
          w_intr_nxt   = '0;
          w_addr_nxt   = '0;
          w_col_nxt    = '0;
          w_state_nxt  = S_SEND;
        end
      end
      S_SEND: begin
        w_addr_nxt = r_addr + 1'b1;
        if (w_line_end) begin
          w_col_nxt   = '0;
          w_lines_nxt = r_lines_sent + 1'b1;
          if (w_lines_nxt == LW'(IMG_HEIGHT)) w_state_nxt = S_DRAIN;
          else if (w_credit_nxt != 3'd0)      w_state_nxt = S_SEND;
          else                                w_state_nxt = S_WAIT;
        end else begin
          w_col_nxt = r_col + 1'b1;
        end
      end
      S_WAIT: begin
        if (w_credit_nxt != 3'd0) w_state_nxt = S_SEND;
      end
      S_DRAIN: begin
        if (r_intr_cnt == LW'(IMG_HEIGHT - 2)) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= S_IDLE;
      r_credit     <= '0;
      r_lines_sent <= '0;
      r_intr_cnt   <= '0;
      r_col        <= '0;
      r_addr       <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_credit     <= w_credit_nxt;
      r_lines_sent <= w_lines_nxt;
      r_intr_cnt   <= w_intr_nxt;
      r_col        <= w_col_nxt;
      r_addr       <= w_addr_nxt;
    end
  end

  // Valid tracks the read strobe through both the memory stage and the output register,
  // so it stays aligned with the pixel it qualifies.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rd_d1 <= 1'b0;
      r_valid <= 1'b0;
      r_pix   <= '0;
    end else begin
      r_rd_d1 <= o_mem_rd_en;
      r_valid <= r_rd_d1;
      r_pix   <= i_mem_data;
    end
  end

  assign o_mem_addr         = r_addr;
  assign o_mem_rd_en        = (r_state == S_SEND);
  assign o_busy             = (r_state != S_IDLE);
  assign o_done             = (r_state == S_DONE);
  assign o_pixel_data       = r_pix;
  assign o_pixel_data_valid = r_valid;

endmodule

// File: tb/tb_image_feeder.sv
// Directed and randomized bench for image_feeder on an 8x6 frame with a synchronous
// memory returning data = address.
module tb_image_feeder;

  localparam int W  = 8;
  localparam int H  = 6;
  localparam int AW = 8;
  localparam int DW = 13;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          intr = 1'b0;
  logic [AW-1:0] mem_addr;
  logic          mem_rd_en;
  logic [DW-1:0] mem_data = '0;
  logic [DW-1:0] pix;
  logic          pix_valid;
  logic          busy;
  logic          done;

  image_feeder #(
    .INTEGER_BITS(9),
    .FIXED_POINT_BITS(4),
    .IMG_WIDTH(W),
    .IMG_HEIGHT(H),
    .ADDR_WIDTH(AW)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_start(start),
    .o_mem_addr(mem_addr),
    .o_mem_rd_en(mem_rd_en),
    .i_mem_data(mem_data),
    .o_pixel_data(pix),
    .o_pixel_data_valid(pix_valid),
    .i_intr(intr),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (mem_rd_en) mem_data <= {{(DW-AW){1'b0}}, mem_addr};

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned rd_cnt = 0;
  int unsigned done_cnt = 0;
  logic [DW-1:0] got[$];
  logic          p1v = 1'b0, p2v = 1'b0;
  logic [AW-1:0] p1a = '0, p2a = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Monitor: reads must walk the raster contiguously; each pixel equals the address
  // presented two cycles earlier.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_cnt = 0; done_cnt = 0; got.delete();
      p1v = 1'b0; p2v = 1'b0;
    end else begin
      if (pix_valid) begin
        check("lat2_valid", {31'd0, p2v}, 32'd1);
        check("lat2_data", {19'd0, pix}, {24'd0, p2a});
        got.push_back(pix);
      end
      p2v = p1v; p2a = p1a;
      p1v = mem_rd_en; p1a = mem_addr;
      if (mem_rd_en) begin
        check("rd_addr", {24'd0, mem_addr}, rd_cnt);
        rd_cnt++;
      end
      if (done) done_cnt++;
    end
  end

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic pulse_intr();
    intr = 1'b1; tick(); intr = 1'b0;
  endtask

  task automatic begin_frame();
    got.delete(); rd_cnt = 0; done_cnt = 0;
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic wait_reads(input int unsigned n, input int unsigned budget);
    int unsigned k = 0;
    while (rd_cnt < n && k < budget) begin tick(); k++; end
    check("reach_reads", rd_cnt, n);
  endtask

  task automatic wait_done(input int unsigned budget);
    int unsigned k = 0;
    while (done_cnt == 0 && k < budget) begin tick(); k++; end
    tick(); tick();
    check("done_once", done_cnt, 1);
    check("busy_after", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_frame();
    check("pix_count", got.size(), W * H);
    for (int i = 0; i < W * H && i < got.size(); i++)
      check("pix_order", {19'd0, got[i]}, i);
  endtask

  int unsigned given, lim, k;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_addr", {24'd0, mem_addr}, 0);
    check("rst_rd", {31'd0, mem_rd_en}, 0);
    check("rst_pix", {19'd0, pix}, 0);
    check("rst_valid", {31'd0, pix_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    rst_n = 1'b1;
    pulse_intr();
    repeat (2) tick();
    check("idle_intr_ignored", {31'd0, mem_rd_en}, 0);

    // Frame 1: preload, credit stalls, start while busy, done timing
    begin_frame();
    check("start_rd", {31'd0, mem_rd_en}, 1);
    check("start_addr", {24'd0, mem_addr}, 0);
    check("start_busy", {31'd0, busy}, 1);
    wait_reads(4 * W, 100);
    repeat (10) tick();
    check("stall_rd", {31'd0, mem_rd_en}, 0);
    check("stall_addr", {24'd0, mem_addr}, 4 * W);
    check("stall_cnt", rd_cnt, 4 * W);
    check("stall_credit", {29'd0, dut.r_credit}, 0);
    start = 1'b1; tick(); start = 1'b0;
    repeat (4) tick();
    check("busy_start_addr", {24'd0, mem_addr}, 4 * W);
    check("busy_start_cnt", rd_cnt, 4 * W);
    repeat ($urandom_range(0, 5)) tick();
    pulse_intr();
    check("resume_rd", {31'd0, mem_rd_en}, 1);
    check("resume_addr", {24'd0, mem_addr}, 4 * W);
    wait_reads(5 * W, 50);
    repeat (10) tick();
    check("stall2_cnt", rd_cnt, 5 * W);
    check("stall2_rd", {31'd0, mem_rd_en}, 0);
    pulse_intr();
    wait_reads(6 * W, 50);
    repeat (10) tick();
    check("drain_cnt", rd_cnt, 6 * W);
    check("drain_done", done_cnt, 0);
    check("drain_busy", {31'd0, busy}, 1);
    pulse_intr();
    repeat (3) tick();
    check("early_done", done_cnt, 0);
    pulse_intr();
    check("done_lag", {31'd0, done}, 0);
    tick();
    check("done_pulse", {31'd0, done}, 1);
    tick();
    check("done_end", {31'd0, done}, 0);
    check("idle_busy", {31'd0, busy}, 0);
    check("f1_done_cnt", done_cnt, 1);
    check_frame();

    // Frame 2: asynchronous reset mid-line
    begin_frame();
    wait_reads(13, 50);
    #1 rst_n = 1'b0;
    #1;
    check("arst_addr", {24'd0, mem_addr}, 0);
    check("arst_rd", {31'd0, mem_rd_en}, 0);
    check("arst_pix", {19'd0, pix}, 0);
    check("arst_valid", {31'd0, pix_valid}, 0);
    check("arst_busy", {31'd0, busy}, 0);
    check("arst_done", {31'd0, done}, 0);
    tick();
    rst_n = 1'b1;
    tick();
    check("post_rst_rd", {31'd0, mem_rd_en}, 0);

    // Frame 3: interrupt on last pixel at zero credit, interrupt on a line start
    begin_frame();
    check("f3_first_addr", {24'd0, mem_addr}, 0);
    wait_reads(4 * W, 100);
    repeat (3) tick();
    pulse_intr();
    k = 0;
    while (!(mem_rd_en && mem_addr == AW'(5 * W - 1)) && k < 50) begin tick(); k++; end
    check("last_pix_seen", {24'd0, mem_addr}, 5 * W - 1);
    check("last_pix_credit", {29'd0, dut.r_credit}, 0);
    intr = 1'b1; tick();
    check("nobubble_rd", {31'd0, mem_rd_en}, 1);
    check("nobubble_addr", {24'd0, mem_addr}, 5 * W);
    tick(); intr = 1'b0;
    check("coincide_credit", {29'd0, dut.r_credit}, 1);
    check("coincide_addr", {24'd0, mem_addr}, 5 * W + 1);
    wait_reads(6 * W, 50);
    repeat ($urandom_range(1, 6)) tick();
    pulse_intr();
    wait_done(50);
    check_frame();

    // Frames 4-5: random interrupt timing from a downstream that only returns
    // interrupts for fully received lines.
    for (int f = 0; f < 2; f++) begin
      begin_frame();
      given = 0; k = 0;
      while (done_cnt == 0 && k < 400) begin
        lim = (4 + given < H) ? 4 + given : H;
        check("read_bound", {31'd0, rd_cnt <= W * lim}, 1);
        check("credit_max", {31'd0, dut.r_credit <= 3'd4}, 1);
        if (given < H - 2 && given + 2 < got.size() / W && ($urandom % 3) == 0) begin
          intr = 1'b1; given++;
        end else begin
          intr = 1'b0;
        end
        tick(); k++;
      end
      intr = 1'b0;
      wait_done(10);
      check_frame();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
